// File: rtl/decode_ctrl_stage.sv
// Decode/control pipeline stage: decodes RV32I(+M) opcode fields into a registered
// control bundle, with a valid/ready handshake and an MDU occupancy stall counter.
module decode_ctrl_stage #(
    parameter int OP_W     = 7,
    parameter int F3_W     = 3,
    parameter int F7_W     = 7,
    parameter int ALU_OP_W = 3,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     opcode,
    input  logic [F3_W-1:0]     funct3,
    input  logic [F7_W-1:0]     funct7,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                has_imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_alt,
    output logic                rf_we,
    output logic                mem_we,
    output logic                mem2rf,
    output logic [1:0]          mem_size,
    output logic                mem_unsigned,
    output logic                branch,
    output logic                check_eq,
    output logic                jump,
    output logic                is_imm20,
    output logic                is_lui,
    output logic                is_auipc,
    output logic                mdu,
    output logic [2:0]          mdu_op,
    output logic                illegal,
    output logic                mdu_busy
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [OP_W-1:0] OPC_OP_IMM = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OPC_OP     = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OPC_LOAD   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OPC_STORE  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OPC_BRANCH = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OPC_JAL    = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0] OPC_JALR   = OP_W'(7'b1100111);
    localparam logic [OP_W-1:0] OPC_LUI    = OP_W'(7'b0110111);
    localparam logic [OP_W-1:0] OPC_AUIPC  = OP_W'(7'b0010111);

    localparam logic [F3_W-1:0] F3_ADD = F3_W'(3'b000);
    localparam logic [F3_W-1:0] F3_SL  = F3_W'(3'b001);
    localparam logic [F3_W-1:0] F3_SR  = F3_W'(3'b101);
    localparam logic [F7_W-1:0] F7_BASE = F7_W'(7'b0000000);
    localparam logic [F7_W-1:0] F7_ALT  = F7_W'(7'b0100000);
    localparam logic [F7_W-1:0] F7_MD   = F7_W'(7'b0000001);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_MDU_BUSY = 2'd2
    } state_t;

    typedef struct packed {
        logic                has_imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_alt;
        logic                rf_we;
        logic                mem_we;
        logic                mem2rf;
        logic [1:0]          mem_size;
        logic                mem_unsigned;
        logic                branch;
        logic                check_eq;
        logic                jump;
        logic                is_imm20;
        logic                is_lui;
        logic                is_auipc;
        logic                mdu;
        logic [2:0]          mdu_op;
        logic                illegal;
    } bundle_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    bundle_t            bundle_q, bundle_d;
    bundle_t            dec_s;
    logic               out_valid_q, out_valid_d;
    logic               mdu_busy_q, mdu_busy_d;
    logic               accept_s;
    logic [CNT_W-1:0]   lat_s;

    // Combinational instruction decode; illegal encodings squash side-effecting fields.
    always_comb begin
        dec_s = '0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_s.rf_we   = 1'b1;
                dec_s.has_imm = 1'b1;
                dec_s.alu_op  = ALU_OP_W'(funct3);
                dec_s.alu_alt = (funct3 == F3_SR) & funct7[5];
                dec_s.illegal = ((funct3 == F3_SL) && (funct7 != F7_BASE)) ||
                                ((funct3 == F3_SR) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec_s.rf_we  = 1'b1;
                    dec_s.alu_op = ALU_OP_W'(funct3);
                end else if ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))) begin
                    dec_s.rf_we   = 1'b1;
                    dec_s.alu_op  = ALU_OP_W'(funct3);
                    dec_s.alu_alt = 1'b1;
                end else if ((funct7 == F7_MD) && (ENABLE_M != 0)) begin
                    dec_s.rf_we  = 1'b1;
                    dec_s.mdu    = 1'b1;
                    dec_s.mdu_op = funct3[2:0];
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_s.has_imm      = 1'b1;
                dec_s.rf_we        = 1'b1;
                dec_s.mem2rf       = 1'b1;
                dec_s.mem_size     = funct3[1:0];
                dec_s.mem_unsigned = funct3[2];
                dec_s.illegal      = (funct3 == F3_W'(3'b011)) || (funct3 == F3_W'(3'b110)) ||
                                     (funct3 == F3_W'(3'b111));
            end
            OPC_STORE: begin
                dec_s.has_imm  = 1'b1;
                dec_s.mem_we   = 1'b1;
                dec_s.mem_size = funct3[1:0];
                dec_s.illegal  = (funct3 >= F3_W'(3'b011));
            end
            OPC_BRANCH: begin
                dec_s.branch   = 1'b1;
                dec_s.alu_alt  = ~funct3[2];
                dec_s.alu_op   = ALU_OP_W'({1'b0, funct3[2:1]});
                dec_s.check_eq = funct3[0] ^ ~funct3[2];
                dec_s.illegal  = (funct3 == F3_W'(3'b010)) || (funct3 == F3_W'(3'b011));
            end
            OPC_JAL: begin
                dec_s.jump     = 1'b1;
                dec_s.is_imm20 = 1'b1;
                dec_s.rf_we    = 1'b1;
            end
            OPC_JALR: begin
                dec_s.jump    = 1'b1;
                dec_s.has_imm = 1'b1;
                dec_s.rf_we   = 1'b1;
                dec_s.illegal = (funct3 != F3_ADD);
            end
            OPC_LUI: begin
                dec_s.rf_we    = 1'b1;
                dec_s.is_imm20 = 1'b1;
                dec_s.is_lui   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s.rf_we    = 1'b1;
                dec_s.is_imm20 = 1'b1;
                dec_s.is_auipc = 1'b1;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        dec_s.rf_we  = dec_s.rf_we  & ~dec_s.illegal;
        dec_s.mem_we = dec_s.mem_we & ~dec_s.illegal;
        dec_s.mem2rf = dec_s.mem2rf & ~dec_s.illegal;
        dec_s.branch = dec_s.branch & ~dec_s.illegal;
        dec_s.jump   = dec_s.jump   & ~dec_s.illegal;
        dec_s.mdu    = dec_s.mdu    & ~dec_s.illegal;
    end

    // Handshake and next-state logic; an MDU hand-off never overlaps a new accept.
    always_comb begin
        in_ready = ~rst & ~flush &
                   ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready && ~bundle_q.mdu));
        accept_s = in_valid & in_ready;
        lat_s    = bundle_q.mdu_op[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        state_d  = state_q;
        cnt_d    = cnt_q;
        bundle_d = bundle_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d  = ST_FULL;
                    bundle_d = dec_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (out_ready && bundle_q.mdu) begin
                    if (lat_s == CNT_W'(1)) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_MDU_BUSY;
                        cnt_d   = lat_s - CNT_W'(1);
                    end
                end else if (out_ready) begin
                    if (accept_s) begin
                        state_d  = ST_FULL;
                        bundle_d = dec_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_MDU_BUSY: begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? ST_EMPTY : ST_MDU_BUSY;
            end
            default: begin
                state_d = ST_EMPTY;
                cnt_d   = '0;
            end
        endcase
        out_valid_d = (state_d == ST_FULL);
        mdu_busy_d  = (state_d == ST_MDU_BUSY);
    end

    // State, counter and bundle registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            mdu_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            mdu_busy_q  <= mdu_busy_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign mdu_busy     = mdu_busy_q;
    assign has_imm      = bundle_q.has_imm;
    assign alu_op       = bundle_q.alu_op;
    assign alu_alt      = bundle_q.alu_alt;
    assign rf_we        = bundle_q.rf_we;
    assign mem_we       = bundle_q.mem_we;
    assign mem2rf       = bundle_q.mem2rf;
    assign mem_size     = bundle_q.mem_size;
    assign mem_unsigned = bundle_q.mem_unsigned;
    assign branch       = bundle_q.branch;
    assign check_eq     = bundle_q.check_eq;
    assign jump         = bundle_q.jump;
    assign is_imm20     = bundle_q.is_imm20;
    assign is_lui       = bundle_q.is_lui;
    assign is_auipc     = bundle_q.is_auipc;
    assign mdu          = bundle_q.mdu;
    assign mdu_op       = bundle_q.mdu_op;
    assign illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: decode table through a scoreboard plus
// hand-written handshake, MDU stall, flush and reset sequences.
module tb_decode_ctrl_stage;

    typedef struct packed {
        logic       has_imm;
        logic [2:0] alu_op;
        logic       alu_alt;
        logic       rf_we;
        logic       mem_we;
        logic       mem2rf;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       branch;
        logic       check_eq;
        logic       jump;
        logic       is_imm20;
        logic       is_lui;
        logic       is_auipc;
        logic       mdu;
        logic [2:0] mdu_op;
        logic       illegal;
    } bund_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bund_t      e;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, in_valid, nm_valid, out_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic in_ready, out_valid, has_imm, alu_alt, rf_we, mem_we, mem2rf, mem_unsigned;
    logic branch, check_eq, jump, is_imm20, is_lui, is_auipc, mdu, illegal, mdu_busy;
    logic [2:0] alu_op, mdu_op;
    logic [1:0] mem_size;

    logic nm_in_ready, nm_out_valid, nm_has_imm, nm_alu_alt, nm_rf_we, nm_mem_we, nm_mem2rf;
    logic nm_mem_unsigned, nm_branch, nm_check_eq, nm_jump, nm_is_imm20, nm_is_lui, nm_is_auipc;
    logic nm_mdu, nm_illegal, nm_mdu_busy;
    logic [2:0] nm_alu_op, nm_mdu_op;
    logic [1:0] nm_mem_size;

    bund_t act_b, nm_b, cur_exp, e;
    bund_t sb_q[$];
    row_t  tbl[$];
    int    tests = 0;
    int    fails = 0;

    assign act_b = {has_imm, alu_op, alu_alt, rf_we, mem_we, mem2rf, mem_size, mem_unsigned,
                    branch, check_eq, jump, is_imm20, is_lui, is_auipc, mdu, mdu_op, illegal};
    assign nm_b  = {nm_has_imm, nm_alu_op, nm_alu_alt, nm_rf_we, nm_mem_we, nm_mem2rf, nm_mem_size,
                    nm_mem_unsigned, nm_branch, nm_check_eq, nm_jump, nm_is_imm20, nm_is_lui,
                    nm_is_auipc, nm_mdu, nm_mdu_op, nm_illegal};

    decode_ctrl_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
        .out_ready(out_ready), .has_imm(has_imm), .alu_op(alu_op), .alu_alt(alu_alt),
        .rf_we(rf_we), .mem_we(mem_we), .mem2rf(mem2rf), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .branch(branch), .check_eq(check_eq), .jump(jump),
        .is_imm20(is_imm20), .is_lui(is_lui), .is_auipc(is_auipc), .mdu(mdu),
        .mdu_op(mdu_op), .illegal(illegal), .mdu_busy(mdu_busy)
    );

    decode_ctrl_stage #(.ENABLE_M(0)) u_nom (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(nm_valid), .in_ready(nm_in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(nm_out_valid),
        .out_ready(out_ready), .has_imm(nm_has_imm), .alu_op(nm_alu_op), .alu_alt(nm_alu_alt),
        .rf_we(nm_rf_we), .mem_we(nm_mem_we), .mem2rf(nm_mem2rf), .mem_size(nm_mem_size),
        .mem_unsigned(nm_mem_unsigned), .branch(nm_branch), .check_eq(nm_check_eq),
        .jump(nm_jump), .is_imm20(nm_is_imm20), .is_lui(nm_is_lui), .is_auipc(nm_is_auipc),
        .mdu(nm_mdu), .mdu_op(nm_mdu_op), .illegal(nm_illegal), .mdu_busy(nm_mdu_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop on transfer (compare) or on flush (discard).
    always @(negedge clk) begin
        bund_t exp_b;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && (flush || out_ready)) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_b = sb_q.pop_front();
                    if (!flush) chk("bundle", 32'(act_b), 32'(exp_b));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input bund_t ex, output int waited);
        opcode = op; funct3 = f3; funct7 = f7; cur_exp = ex; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic stall_test(input string nm, input logic [2:0] f3, input int exp_cycles);
        int w, cnt, k;
        bund_t ex;
        ex = '0; ex.rf_we = 1'b1; ex.mdu = 1'b1; ex.mdu_op = f3;
        send(7'b0110011, f3, 7'b0000001, ex, w);
        @(negedge clk);
        chk({nm, "_blocks_accept"}, 32'(in_ready), 32'd0);
        cnt = 0; k = 0;
        @(negedge clk);
        while (mdu_busy && k < 40) begin
            if (!in_ready) cnt++;
            k++;
            @(negedge clk);
        end
        chk({nm, "_stall_len"}, 32'(cnt), 32'(exp_cycles));
        chk({nm, "_ready_after"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1;
        bund_t lw;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; nm_valid = 1'b0; out_ready = 1'b1;
        opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; cur_exp = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("rst_bundle", 32'(act_b), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADD then SUB back-to-back
        e = '0; e.rf_we = 1'b1;
        send(7'b0110011, 3'b000, 7'b0000000, e, w0);
        e.alu_alt = 1'b1;
        send(7'b0110011, 3'b000, 7'b0100000, e, w1);
        chk("add_wait", 32'(w0), 32'd0);
        chk("sub_wait", 32'(w1), 32'd0);
        @(negedge clk);
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_alt", 32'(alu_alt), 32'd1);
        @(posedge clk); #1;

        // Decode table
        e = '0; e.rf_we = 1'b1; e.alu_op = 3'b101; e.alu_alt = 1'b1;
        tbl.push_back('{7'b0110011, 3'b101, 7'b0100000, e});             // SRA
        e = '0; e.illegal = 1'b1;
        tbl.push_back('{7'b0110011, 3'b110, 7'b0100000, e});             // OR w/ alt: illegal
        e = '0; e.has_imm = 1'b1; e.alu_op = 3'b101; e.alu_alt = 1'b1; e.rf_we = 1'b1;
        tbl.push_back('{7'b0010011, 3'b101, 7'b0100000, e});             // SRAI
        e = '0; e.has_imm = 1'b1; e.alu_op = 3'b001; e.illegal = 1'b1;
        tbl.push_back('{7'b0010011, 3'b001, 7'b0100000, e});             // SLLI bad funct7
        e = '0; e.has_imm = 1'b1; e.rf_we = 1'b1;
        tbl.push_back('{7'b0010011, 3'b000, 7'b1111111, e});             // ADDI
        e = '0; e.has_imm = 1'b1; e.alu_op = 3'b101; e.rf_we = 1'b1;
        tbl.push_back('{7'b0010011, 3'b101, 7'b0000000, e});             // SRLI
        e = '0; e.has_imm = 1'b1; e.alu_op = 3'b101; e.alu_alt = 1'b1; e.illegal = 1'b1;
        tbl.push_back('{7'b0010011, 3'b101, 7'b0100001, e});             // shift bad funct7
        e = '0; e.has_imm = 1'b1; e.rf_we = 1'b1; e.mem2rf = 1'b1; e.mem_size = 2'b10;
        tbl.push_back('{7'b0000011, 3'b010, 7'b0000000, e});             // LW
        e = '0; e.has_imm = 1'b1; e.rf_we = 1'b1; e.mem2rf = 1'b1; e.mem_unsigned = 1'b1;
        tbl.push_back('{7'b0000011, 3'b100, 7'b0000000, e});             // LBU
        e = '0; e.has_imm = 1'b1; e.mem_size = 2'b11; e.illegal = 1'b1;
        tbl.push_back('{7'b0000011, 3'b011, 7'b0000000, e});             // LD: illegal
        e = '0; e.has_imm = 1'b1; e.mem_we = 1'b1; e.mem_size = 2'b01;
        tbl.push_back('{7'b0100011, 3'b001, 7'b0000000, e});             // SH
        e = '0; e.has_imm = 1'b1; e.mem_size = 2'b11; e.illegal = 1'b1;
        tbl.push_back('{7'b0100011, 3'b011, 7'b0000000, e});             // SD: illegal
        e = '0; e.branch = 1'b1; e.alu_alt = 1'b1; e.check_eq = 1'b1;
        tbl.push_back('{7'b1100011, 3'b000, 7'b0000000, e});             // BEQ
        e = '0; e.branch = 1'b1; e.alu_alt = 1'b1;
        tbl.push_back('{7'b1100011, 3'b001, 7'b0000000, e});             // BNE
        e = '0; e.branch = 1'b1; e.alu_op = 3'b010;
        tbl.push_back('{7'b1100011, 3'b100, 7'b0000000, e});             // BLT
        e = '0; e.branch = 1'b1; e.alu_op = 3'b011; e.check_eq = 1'b1;
        tbl.push_back('{7'b1100011, 3'b111, 7'b0000000, e});             // BGEU
        e = '0; e.alu_alt = 1'b1; e.alu_op = 3'b001; e.check_eq = 1'b1; e.illegal = 1'b1;
        tbl.push_back('{7'b1100011, 3'b010, 7'b0000000, e});             // branch 010: illegal
        e = '0; e.jump = 1'b1; e.is_imm20 = 1'b1; e.rf_we = 1'b1;
        tbl.push_back('{7'b1101111, 3'b101, 7'b0000000, e});             // JAL
        e = '0; e.jump = 1'b1; e.has_imm = 1'b1; e.rf_we = 1'b1;
        tbl.push_back('{7'b1100111, 3'b000, 7'b0000000, e});             // JALR
        e = '0; e.has_imm = 1'b1; e.illegal = 1'b1;
        tbl.push_back('{7'b1100111, 3'b001, 7'b0000000, e});             // JALR bad funct3
        e = '0; e.rf_we = 1'b1; e.is_imm20 = 1'b1; e.is_lui = 1'b1;
        tbl.push_back('{7'b0110111, 3'b000, 7'b0000000, e});             // LUI
        e = '0; e.rf_we = 1'b1; e.is_imm20 = 1'b1; e.is_auipc = 1'b1;
        tbl.push_back('{7'b0010111, 3'b000, 7'b0000000, e});             // AUIPC
        e = '0; e.illegal = 1'b1;
        tbl.push_back('{7'b1111111, 3'b000, 7'b0000000, e});             // unknown opcode
        e = '0; e.rf_we = 1'b1; e.mdu = 1'b1;
        tbl.push_back('{7'b0110011, 3'b000, 7'b0000001, e});             // MUL
        e = '0; e.rf_we = 1'b1; e.mdu = 1'b1; e.mdu_op = 3'b101;
        tbl.push_back('{7'b0110011, 3'b101, 7'b0000001, e});             // DIVU
        foreach (tbl[i]) send(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].e, w0);
        repeat (12) @(posedge clk);
        #1;

        // MDU occupancy stalls
        stall_test("div", 3'b100, 7);
        stall_test("mul", 3'b000, 2);

        // Held LW under back-pressure, then flush
        out_ready = 1'b0;
        lw = '0; lw.has_imm = 1'b1; lw.rf_we = 1'b1; lw.mem2rf = 1'b1; lw.mem_size = 2'b10;
        send(7'b0000011, 3'b010, 7'b0000000, lw, w0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            flush = (c == 2);
            @(negedge clk);
            if (c < 3) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_bundle", 32'(act_b), 32'(lw));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end else begin
                chk("flush_valid", 32'(out_valid), 32'd0);
                chk("flush_in_ready", 32'(in_ready), 32'd1);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset in the middle of a DIV stall
        e = '0; e.rf_we = 1'b1; e.mdu = 1'b1; e.mdu_op = 3'b100;
        send(7'b0110011, 3'b100, 7'b0000001, e, w0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy_before", 32'(mdu_busy), 32'd1);
        chk("rst_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // M extension disabled: MUL is illegal
        opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000001; nm_valid = 1'b1;
        @(negedge clk);
        chk("nom_in_ready", 32'(nm_in_ready), 32'd1);
        @(posedge clk); #1;
        nm_valid = 1'b0;
        @(negedge clk);
        e = '0; e.illegal = 1'b1;
        chk("nom_valid", 32'(nm_out_valid), 32'd1);
        chk("nom_bundle", 32'(nm_b), 32'(e));
        chk("nom_busy", 32'(nm_mdu_busy), 32'd0);
        @(posedge clk); #1;

        repeat (4) @(posedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameter OP_W, default 7, opcode width.
REQ-002 Parameter F3_W, default 3, funct3 width.
REQ-003 Parameter F7_W, default 7, funct7 width.
REQ-004 Parameter ALU_OP_W, default 3, ALU operation width.
REQ-005 Parameter ENABLE_M, default 1, enables RV32M decode; when 0, M encodings SHALL decode as illegal.
REQ-006 Parameter MUL_LAT, default 3, MDU occupancy in cycles for funct3[2]=0; legal range >=1.
REQ-007 Parameter DIV_LAT, default 8, MDU occupancy in cycles for funct3[2]=1; legal range >=1.
REQ-008 Ports, in order:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill held instruction.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- opcode  in  OP_W  instruction opcode.
- funct3  in  F3_W  instruction funct3.
- funct7  in  F7_W  instruction funct7.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- Registered bundle outputs:
  - has_imm, alu_op[ALU_OP_W], alu_alt, rf_we, mem_we, mem2rf.
  - mem_size[2], mem_unsigned.
  - branch, check_eq, jump, is_imm20, is_lui, is_auipc.
  - mdu, mdu_op[3], illegal.
- mdu_busy  out  1  MDU occupancy stall active.

Function
REQ-009 The FSM SHALL have three states:
- EMPTY
- FULL
- MDU_BUSY
REQ-010 in_ready SHALL be 1 in EMPTY and in FULL when out_ready=1, and SHALL be 0 in all other cases, including MDU_BUSY, rst=1, and flush=1.
REQ-011 Accept (in_valid & in_ready) SHALL register the decoded bundle and set out_valid=1 on the next edge; latency is 1 cycle.
REQ-012 Transfer (out_valid & out_ready) without a same-cycle accept SHALL clear out_valid.
REQ-013 If the transferred bundle has mdu=1, the FSM SHALL enter MDU_BUSY and load the counter with LAT-1, where LAT is MUL_LAT or DIV_LAT selected by mdu_op[2].
REQ-014 If LAT=1, the FSM SHALL return to EMPTY with no stall.
REQ-015 An mdu=1 transfer SHALL block a same-cycle accept.
REQ-016 In MDU_BUSY, mdu_busy SHALL be 1 and the counter SHALL decrement each cycle; when the counter is 1, the next state SHALL be EMPTY.
REQ-017 The bundle SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 flush=1 SHALL clear out_valid and move FULL to EMPTY, and SHALL take priority over a same-cycle accept and transfer.
REQ-019 flush SHALL NOT cancel MDU_BUSY; counting SHALL continue.
REQ-020 Decode of OP-IMM (0010011):
- rf_we=1, has_imm=1, alu_op=funct3.
- alu_alt=(funct3==101)&funct7[5].
- Illegal if funct3=001 and funct7!=0.
- Illegal if funct3=101 and funct7 is not 0000000 or 0100000.
REQ-021 Decode of OP (0110011):
- funct7=0000000: rf_we=1, alu_op=funct3, alu_alt=0.
- funct7=0100000 with funct3 000 or 101: rf_we=1, alu_op=funct3, alu_alt=1.
- funct7=0000001 with ENABLE_M=1: rf_we=1, mdu=1, mdu_op=funct3.
- Otherwise illegal.
REQ-022 Decode of LOAD (0000011):
- has_imm=1, rf_we=1, mem2rf=1.
- mem_size=funct3[1:0], mem_unsigned=funct3[2].
- Illegal if funct3 is 011, 110 or 111.
REQ-023 Decode of STORE (0100011):
- has_imm=1, mem_we=1, mem_size=funct3[1:0].
- Illegal if funct3>=011.
REQ-024 Decode of BRANCH (1100011):
- branch=1, alu_alt=~funct3[2], alu_op={0,funct3[2:1]}.
- check_eq=funct3[0]^~funct3[2].
- Illegal if funct3 is 010 or 011.
REQ-025 Decode of the jump opcodes:
- JAL (1101111): jump=1, is_imm20=1, rf_we=1.
- JALR (1100111): jump=1, has_imm=1, rf_we=1; illegal if funct3!=000.
REQ-026 Decode of the upper-immediate opcodes:
- LUI (0110111): rf_we=1, is_imm20=1, is_lui=1.
- AUIPC (0010111): rf_we=1, is_imm20=1, is_auipc=1.
REQ-027 Any other opcode SHALL set illegal=1.
REQ-028 Unlisted bundle fields SHALL be 0.
REQ-029 illegal=1 SHALL force rf_we, mem_we, mem2rf, branch, jump and mdu to 0; out_valid SHALL still assert so that a later stage can trap.

Reset
REQ-030 On rst=1 at a clock edge, the state SHALL be EMPTY, the counter 0, out_valid 0, mdu_busy 0, and every bundle output 0.
REQ-031 Reset SHALL abort MDU_BUSY immediately.
REQ-032 The first accept SHALL be possible in the cycle after rst falls.

Verification
REQ-033 ADD (0110011/000/0000000) then SUB, with out_ready=1: out_valid rises 1 cycle after each accept; SUB gives alu_alt=1, rf_we=1, illegal=0; throughput 1 per cycle.
REQ-034 DIV (funct7=0000001, funct3=100) with DIV_LAT=8: after transfer, mdu_busy=1 and in_ready=0 for exactly 7 cycles, then in_ready=1; MUL with MUL_LAT=3 stalls 2 cycles.
REQ-035 out_ready=0 for 4 cycles with a LW (funct3=010) held: bundle stable (mem2rf=1, mem_size=10), in_ready=0; flush on cycle 3 clears out_valid next cycle and in_ready=1.
REQ-036 Opcode 1111111, then SLLI with funct7=0100000, then JALR with funct3=001: each gives out_valid=1, illegal=1, rf_we=0, jump=0.
REQ-037 Assert rst mid-MDU_BUSY (counter=4): next cycle mdu_busy=0, out_valid=0, state EMPTY; with ENABLE_M=0, MUL decodes illegal=1, mdu=0.
